spart_driver: RTL and testbench



---
 rtl/spart_driver.sv | 108 ++++++++++
 tb/tb_spart_driver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spart_driver.sv
// Processor-side bus master for the spart: programs the baud divisor from the
// board switches, then echoes every received byte back out.
module spart_driver #(
  parameter logic [15:0] DIV_4800  = 16'd1301,
  parameter logic [15:0] DIV_9600  = 16'd650,
  parameter logic [15:0] DIV_19200 = 16'd325,
  parameter logic [15:0] DIV_38400 = 16'd162
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  br_cfg,
  output logic        iocs,
  output logic        iorw,
  output logic [1:0]  ioaddr,
  input  logic        rda,
  input  logic        tbr,
  inout  wire  [7:0]  databus,
  output logic [7:0]  last_byte,
  output logic [15:0] echo_cnt
);

  typedef enum logic [2:0] {
    INIT, WR_DLO, WR_DHI, IDLE, RD_DATA, WAIT_TBR, WR_DATA, HOLD
  } state_t;

  state_t      state, next_state;
  logic [1:0]  cfg_q;
  logic [7:0]  rx_q;
  logic [15:0] div;
  logic [7:0]  wr_data;

  always_comb begin
    div = DIV_4800;
    case (cfg_q)
      2'b00:   div = DIV_4800;
      2'b01:   div = DIV_9600;
      2'b10:   div = DIV_19200;
      default: div = DIV_38400;
    endcase
  end

  // Bus outputs follow the state alone; reset forces the bus quiet immediately.
  always_comb begin
    next_state = state;
    iocs       = 1'b0;
    iorw       = 1'b1;
    ioaddr     = 2'b00;
    wr_data    = 8'h00;
    case (state)
      INIT:     next_state = WR_DLO;
      WR_DLO:   next_state = WR_DHI;
      WR_DHI:   next_state = IDLE;
      IDLE: begin
        if (br_cfg != cfg_q) next_state = INIT;
        else if (rda)        next_state = RD_DATA;
      end
      RD_DATA:  next_state = WAIT_TBR;
      WAIT_TBR: if (tbr) next_state = WR_DATA;
      WR_DATA:  next_state = HOLD;
      HOLD:     next_state = IDLE;
      default:  next_state = INIT;
    endcase
    if (!rst) begin
      case (state)
        WR_DLO: begin
          iocs    = 1'b1;
          iorw    = 1'b0;
          ioaddr  = 2'b10;
          wr_data = div[7:0];
        end
        WR_DHI: begin
          iocs    = 1'b1;
          iorw    = 1'b0;
          ioaddr  = 2'b11;
          wr_data = div[15:8];
        end
        RD_DATA: iocs = 1'b1;
        WR_DATA: begin
          iocs    = 1'b1;
          iorw    = 1'b0;
          wr_data = rx_q;
        end
        default: ;
      endcase
    end
  end

  assign databus = (iocs && !iorw) ? wr_data : 8'hzz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      cfg_q     <= 2'b00;
      rx_q      <= 8'h00;
      last_byte <= 8'h00;
      echo_cnt  <= 16'h0000;
    end else begin
      state <= next_state;
      if (state == INIT)    cfg_q <= br_cfg;
      if (state == RD_DATA) rx_q  <= databus;
      if (state == WR_DATA) begin
        last_byte <= rx_q;
        echo_cnt  <= echo_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver: an expected-transaction queue with cycle
// stamps plus echo counters is checked against the bus every cycle.
module tb_spart_driver;

  logic        clk = 1'b0;
  logic        rst, rda, tbr;
  logic [1:0]  br_cfg;
  logic        iocs, iorw;
  logic [1:0]  ioaddr;
  wire  [7:0]  databus;
  logic [7:0]  last_byte;
  logic [15:0] echo_cnt;
  logic [7:0]  spart_rx;

  spart_driver dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .iocs(iocs), .iorw(iorw),
    .ioaddr(ioaddr), .rda(rda), .tbr(tbr), .databus(databus),
    .last_byte(last_byte), .echo_cnt(echo_cnt)
  );

  assign databus = (iocs && iorw) ? spart_rx : 8'hzz;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         rw;
    logic [1:0] addr;
    logic [7:0] data;
    int         at;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        t;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] model_cnt = 16'h0000;
  logic [7:0]  model_last = 8'h00;
  bit          pend = 1'b0;
  logic [7:0]  pend_data;
  bit          prev_iocs = 1'b0;
  logic [1:0]  prev_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void expect_txn(input bit rw, input logic [1:0] addr,
                                     input logic [7:0] data, input int at);
    exp_q.push_back('{rw, addr, data, at});
  endfunction

  // Every bus access must match the head of the expected queue at its cycle.
  always @(negedge clk) begin
    if (rst) begin
      check("bus_quiet_in_reset", {31'd0, iocs}, 32'd0);
      exp_q.delete();
      model_cnt  = 16'h0000;
      model_last = 8'h00;
      pend       = 1'b0;
      prev_iocs  = 1'b0;
    end else begin
      if (pend) begin
        model_cnt  = model_cnt + 16'd1;
        model_last = pend_data;
        pend       = 1'b0;
      end
      check("echo_cnt", {16'd0, echo_cnt}, {16'd0, model_cnt});
      check("last_byte", {24'd0, last_byte}, {24'd0, model_last});
      if (iocs) begin
        if (prev_iocs)
          check("iocs_consecutive", {28'd0, prev_addr, ioaddr}, 32'hB);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("[TB] FAIL unexpected_access: got rw=%0d addr=%0h data=%0h, expected no access (cycle %0d)",
                   iorw, ioaddr, databus, cyc);
        end else begin
          t = exp_q.pop_front();
          check("access_rw", {31'd0, iorw}, {31'd0, t.rw});
          check("access_addr", {30'd0, ioaddr}, {30'd0, t.addr});
          check("access_data", {24'd0, databus}, {24'd0, t.data});
          check("access_cycle", cyc, t.at);
          if (!t.rw && t.addr == 2'b00) begin
            pend      = 1'b1;
            pend_data = t.data;
          end
        end
      end else begin
        check("idle_bus", {29'd0, iorw, ioaddr}, 32'h4);
      end
      prev_iocs = iocs;
      prev_addr = ioaddr;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus_reset(input logic [1:0] cfg, input logic [7:0] lo, input logic [7:0] hi);
    br_cfg = cfg;
    rst    = 1'b1;
    rda    = 1'b0;
    tick(2);
    rst = 1'b0;
    expect_txn(1'b0, 2'b10, lo, cyc + 1);
    expect_txn(1'b0, 2'b11, hi, cyc + 2);
    tick(3);
  endtask

  task automatic apply_stimulus_echo(input logic [7:0] b);
    spart_rx = b;
    rda      = 1'b1;
    tbr      = 1'b1;
    expect_txn(1'b1, 2'b00, b, cyc + 1);
    expect_txn(1'b0, 2'b00, b, cyc + 3);
    tick(1);
    rda = 1'b0;
    tick(4);
  endtask

  task automatic check_output(input string name, input logic [15:0] cnt, input logic [7:0] lb);
    check({name, "_cnt"}, {16'd0, echo_cnt}, {16'd0, cnt});
    check({name, "_last"}, {24'd0, last_byte}, {24'd0, lb});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish, expected finish within 100000 ns");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  logic [7:0] stream_bytes [6] = '{8'h11, 8'h22, 8'h33, 8'hC4, 8'h55, 8'hE6};
  int n;

  initial begin
    rst = 1'b1; rda = 1'b0; tbr = 1'b0; br_cfg = 2'b01; spart_rx = 8'h00;

    // 650 = 16'h028A
    apply_stimulus_reset(2'b01, 8'h8A, 8'h02);
    check_output("after_reset", 16'h0000, 8'h00);

    apply_stimulus_echo(8'hA5);
    check_output("single_echo", 16'h0001, 8'hA5);

    // Back-pressure, with a switch change that must wait until the echo ends.
    n = cyc;
    spart_rx = 8'h3C; rda = 1'b1; tbr = 1'b0;
    expect_txn(1'b1, 2'b00, 8'h3C, n + 1);
    tick(1);
    rda = 1'b0;
    tick(9);
    br_cfg = 2'b00;
    tick(41);
    n = cyc;
    tbr = 1'b1;
    expect_txn(1'b0, 2'b00, 8'h3C, n + 1);
    expect_txn(1'b0, 2'b10, 8'h15, n + 5);
    expect_txn(1'b0, 2'b11, 8'h05, n + 6);
    tick(7);
    check_output("backpressure", 16'h0002, 8'h3C);

    n = cyc;
    br_cfg = 2'b01;
    expect_txn(1'b0, 2'b10, 8'h8A, n + 2);
    expect_txn(1'b0, 2'b11, 8'h02, n + 3);
    tick(4);

    // Switch change and rda together: reprogramming wins, the read follows.
    n = cyc;
    br_cfg = 2'b11; rda = 1'b1; tbr = 1'b1; spart_rx = 8'h5A;
    expect_txn(1'b0, 2'b10, 8'hA2, n + 2);
    expect_txn(1'b0, 2'b11, 8'h00, n + 3);
    expect_txn(1'b1, 2'b00, 8'h5A, n + 5);
    expect_txn(1'b0, 2'b00, 8'h5A, n + 7);
    tick(5);
    rda = 1'b0;
    tick(4);
    check_output("reprogram", 16'h0003, 8'h5A);

    n = cyc;
    spart_rx = 8'h77; rda = 1'b1; tbr = 1'b0;
    expect_txn(1'b1, 2'b00, 8'h77, n + 1);
    tick(1);
    rda = 1'b0;
    tick(1);
    tbr = 1'b1;
    // 325 = 16'h0145
    apply_stimulus_reset(2'b10, 8'h45, 8'h01);
    check_output("reset_mid_echo", 16'h0000, 8'h00);

    force dut.echo_cnt = 16'hFFFD;
    model_cnt = 16'hFFFD;
    #1;
    release dut.echo_cnt;
    tick(1);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus_echo(stream_bytes[i]);
      if (i == 2) check_output("wrap", 16'h0000, 8'h33);
    end
    check_output("stream_end", 16'h0003, 8'hE6);

    tick(3);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
